multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-wait timeout trap. Optional macro ILLEGAL_OPCODE_TRAP_EN sends
// unknown opcodes to TRAP; when undefined they execute as NOPs.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [2:0]  imm_sel,
    input  logic        br_taken,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_imm,
    output logic [2:0]  state,
    output logic        bus_err,
    output logic        illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [2:0]           state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [2:0]           imm_sel_q, imm_sel_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 bus_err_q, bus_err_d;
    logic                 run_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic                 illegal_q, illegal_d;
`endif

    logic [6:0] opcode;
    logic       is_load, is_store, is_branch, is_jal, is_jalr, is_reg, is_wb_type, is_nop_op;

    // Opcode class decode from the registered instruction
    always_comb begin
        opcode     = ir_q[6:0];
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        is_branch  = (opcode == OP_BRANCH);
        is_jal     = (opcode == OP_JAL);
        is_jalr    = (opcode == OP_JALR);
        is_reg     = (opcode == OP_REG);
        is_wb_type = is_reg || is_jal || is_jalr || (opcode == OP_IMM)
                     || (opcode == OP_LUI) || (opcode == OP_AUIPC);
        is_nop_op  = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);
    end

    // Next-state, datapath controls and wait-counter update
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        imm_sel_d    = imm_sel_q;
        bus_err_d    = bus_err_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
        illegal_d    = illegal_q;
`endif
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        alu_src_imm  = !(is_reg || is_branch);

        case (state_q)
            S_FETCH: begin
                // run_q keeps the bus quiet until the first edge after reset
                mem_req = run_q;
                if (run_q) begin
                    if (mem_ack) begin
                        ir_d    = mem_rdata;
                        state_d = S_DECODE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LUI, OP_AUIPC: imm_sel_d = 3'd1;
                    OP_STORE:         imm_sel_d = 3'd3;
                    OP_IMM:           imm_sel_d = 3'd4;
                    OP_BRANCH:        imm_sel_d = 3'd5;
                    OP_JAL:           imm_sel_d = 3'd6;
                    OP_JALR:          imm_sel_d = 3'd7;
                    default:          imm_sel_d = 3'd2;
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_src  = br_taken ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end else if (is_wb_type) begin
                    state_d = S_WB;
                end else if (is_nop_op) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
`else
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (mem_ack) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
                pc_src  = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (mem_ack || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (mem_req) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            imm_sel_q <= 3'd0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_sel_q <= imm_sel_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            run_q     <= 1'b1;
        end
    end

`ifdef ILLEGAL_OPCODE_TRAP_EN
    // Sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign state   = state_q;
    assign ir      = ir_q;
    assign imm_sel = imm_sel_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (TIMEOUT_W = 4).
module tb_multicycle_ctrl;

    localparam int unsigned TW = 4;

    logic        clk;
    logic        rst_n;
    logic        mem_req, mem_we, mem_addr_sel, mem_ack;
    logic [31:0] mem_rdata, ir;
    logic [2:0]  imm_sel, state;
    logic        br_taken, pc_we, reg_we, alu_src_imm, bus_err, illegal;
    logic [1:0]  pc_src, wb_sel;

    int vectors;
    int miscompares;

    multicycle_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .imm_sel(imm_sel),
        .br_taken(br_taken), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .state(state),
        .bus_err(bus_err), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled around the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; br_taken = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Fetch with zero-wait ack and decode; returns positioned in EXEC
    task automatic issue(input logic [31:0] instr, input logic [2:0] exp_imm);
        vectors++; if (state !== 3'd0 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++; $display("FAIL fetch_ctl: state=%0d req=%b sel=%b we=%b exp 0/1/0/0", state, mem_req, mem_addr_sel, mem_we); end
        mem_ack = 1'b1; mem_rdata = instr;
        tick();
        mem_ack = 1'b0; mem_rdata = '0; #1;
        vectors++; if (state !== 3'd1 || ir !== instr) begin
            miscompares++; $display("FAIL decode: state=%0d ir=%h exp 1/%h", state, ir, instr); end
        tick();
        vectors++; if (state !== 3'd2 || imm_sel !== exp_imm) begin
            miscompares++; $display("FAIL exec_imm: state=%0d imm_sel=%0d exp 2/%0d", state, imm_sel, exp_imm); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; br_taken = 1'b0;
        #1;
        vectors++; if (state !== 3'd0 || ir !== 32'd0 || imm_sel !== 3'd0 || bus_err !== 1'b0 || illegal !== 1'b0) begin
            miscompares++; $display("FAIL reset_regs: state=%0d ir=%h imm=%0d berr=%b ill=%b exp all 0", state, ir, imm_sel, bus_err, illegal); end
        vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0) begin
            miscompares++; $display("FAIL reset_en: req=%b we=%b pcwe=%b rwe=%b exp 0", mem_req, mem_we, pc_we, reg_we); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        vectors++; if (mem_req !== 1'b0) begin
            miscompares++; $display("FAIL release_req: got %b exp 0", mem_req); end
        tick();
        vectors++; if (state !== 3'd0 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
            miscompares++; $display("FAIL first_fetch: state=%0d req=%b sel=%b exp 0/1/0", state, mem_req, mem_addr_sel); end
    endtask

    task automatic test_addi();
        issue(32'h00500093, 3'd4);
        vectors++; if (alu_src_imm !== 1'b1 || pc_we !== 1'b0 || reg_we !== 1'b0) begin
            miscompares++; $display("FAIL addi_exec: asi=%b pcwe=%b rwe=%b exp 1/0/0", alu_src_imm, pc_we, reg_we); end
        tick();
        vectors++; if (state !== 3'd4 || reg_we !== 1'b1 || pc_we !== 1'b1 || wb_sel !== 2'd0 || pc_src !== 2'd0) begin
            miscompares++; $display("FAIL addi_wb: state=%0d rwe=%b pcwe=%b wbs=%0d pcs=%0d exp 4/1/1/0/0", state, reg_we, pc_we, wb_sel, pc_src); end
        tick();
        vectors++; if (state !== 3'd0) begin
            miscompares++; $display("FAIL addi_done: state=%0d exp 0", state); end
    endtask

    task automatic test_load();
        issue(32'h0000A103, 3'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ack = 1'b1; #1; end
            vectors++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_we !== 1'b0 || pc_we !== 1'b0) begin
                miscompares++; $display("FAIL load_mem[%0d]: state=%0d req=%b sel=%b we=%b pcwe=%b exp 3/1/1/0/0", i, state, mem_req, mem_addr_sel, mem_we, pc_we); end
            tick();
        end
        mem_ack = 1'b0; #1;
        vectors++; if (state !== 3'd4 || wb_sel !== 2'd1 || reg_we !== 1'b1 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL load_wb: state=%0d wbs=%0d rwe=%b req=%b exp 4/1/1/0", state, wb_sel, reg_we, mem_req); end
        tick();
    endtask

    task automatic test_store();
        issue(32'h0020A023, 3'd3);
        tick();
        vectors++; if (state !== 3'd3 || mem_we !== 1'b1 || mem_addr_sel !== 1'b1 || pc_we !== 1'b0) begin
            miscompares++; $display("FAIL store_wait: state=%0d we=%b sel=%b pcwe=%b exp 3/1/1/0", state, mem_we, mem_addr_sel, pc_we); end
        tick();
        mem_ack = 1'b1; #1;
        vectors++; if (pc_we !== 1'b1 || pc_src !== 2'd0 || reg_we !== 1'b0) begin
            miscompares++; $display("FAIL store_ack: pcwe=%b pcs=%0d rwe=%b exp 1/0/0", pc_we, pc_src, reg_we); end
        tick();
        mem_ack = 1'b0; #1;
        vectors++; if (state !== 3'd0) begin
            miscompares++; $display("FAIL store_done: state=%0d exp 0", state); end
    endtask

    task automatic test_branch();
        br_taken = 1'b1;
        issue(32'h00208463, 3'd5);
        vectors++; if (pc_we !== 1'b1 || pc_src !== 2'd1 || reg_we !== 1'b0 || alu_src_imm !== 1'b0) begin
            miscompares++; $display("FAIL beq_taken: pcwe=%b pcs=%0d rwe=%b asi=%b exp 1/1/0/0", pc_we, pc_src, reg_we, alu_src_imm); end
        br_taken = 1'b0; #1;
        vectors++; if (pc_src !== 2'd0 || pc_we !== 1'b1) begin
            miscompares++; $display("FAIL beq_not_taken: pcs=%0d pcwe=%b exp 0/1", pc_src, pc_we); end
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        vectors++; if (state !== 3'd0 || reg_we !== 1'b0) begin
            miscompares++; $display("FAIL beq_done: state=%0d rwe=%b exp 0/0", state, reg_we); end
    endtask

    logic [31:0] t_ins  [5] = '{32'h000010B7, 32'h00000097, 32'h002081B3, 32'h008000EF, 32'h000080E7};
    logic [2:0]  t_imm  [5] = '{3'd1, 3'd1, 3'd2, 3'd6, 3'd7};
    logic        t_asi  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  t_wbs  [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    logic [1:0]  t_pcs  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};

    task automatic test_wb_types();
        for (int i = 0; i < 5; i++) begin
            issue(t_ins[i], t_imm[i]);
            vectors++; if (alu_src_imm !== t_asi[i] || pc_we !== 1'b0) begin
                miscompares++; $display("FAIL type[%0d]_exec: asi=%b pcwe=%b exp %b/0", i, alu_src_imm, pc_we, t_asi[i]); end
            tick();
            vectors++; if (state !== 3'd4 || reg_we !== 1'b1 || wb_sel !== t_wbs[i] || pc_src !== t_pcs[i]) begin
                miscompares++; $display("FAIL type[%0d]_wb: state=%0d rwe=%b wbs=%0d pcs=%0d exp 4/1/%0d/%0d", i, state, reg_we, wb_sel, pc_src, t_wbs[i], t_pcs[i]); end
            tick();
        end
    endtask

    task automatic test_nop();
        issue(32'h0000000F, 3'd2);
        vectors++; if (pc_we !== 1'b1 || pc_src !== 2'd0 || reg_we !== 1'b0) begin
            miscompares++; $display("FAIL fence_exec: pcwe=%b pcs=%0d rwe=%b exp 1/0/0", pc_we, pc_src, reg_we); end
        tick();
        vectors++; if (state !== 3'd0) begin
            miscompares++; $display("FAIL fence_done: state=%0d exp 0", state); end
    endtask

    task automatic test_timeout_ack();
        for (int i = 0; i < 15; i++) tick();
        vectors++; if (state !== 3'd0 || mem_req !== 1'b1) begin
            miscompares++; $display("FAIL to_ack_wait: state=%0d req=%b exp 0/1", state, mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0; mem_rdata = '0; #1;
        vectors++; if (state !== 3'd1 || bus_err !== 1'b0) begin
            miscompares++; $display("FAIL to_ack_win: state=%0d berr=%b exp 1/0", state, bus_err); end
        tick(); tick(); tick();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 15; i++) tick();
        vectors++; if (state !== 3'd0) begin
            miscompares++; $display("FAIL to_pre: state=%0d exp 0", state); end
        tick();
        vectors++; if (state !== 3'd5 || bus_err !== 1'b1 || mem_req !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++; $display("FAIL to_trap: state=%0d berr=%b req=%b pcwe=%b rwe=%b we=%b exp 5/1/0/0/0/0", state, bus_err, mem_req, pc_we, reg_we, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0;
        vectors++; if (state !== 3'd5 || bus_err !== 1'b1) begin
            miscompares++; $display("FAIL to_sticky: state=%0d berr=%b exp 5/1", state, bus_err); end
        apply_reset();
        vectors++; if (bus_err !== 1'b0 || state !== 3'd0) begin
            miscompares++; $display("FAIL to_clear: berr=%b state=%0d exp 0/0", bus_err, state); end
    endtask

    task automatic test_reset_mid_mem();
        issue(32'h0020A023, 3'd3);
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            miscompares++; $display("FAIL rst_mem_pre: req=%b we=%b exp 1/1", mem_req, mem_we); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 3'd0) begin
            miscompares++; $display("FAIL rst_mem_async: req=%b we=%b state=%0d exp 0/0/0", mem_req, mem_we, state); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        vectors++; if (state !== 3'd0 || mem_addr_sel !== 1'b0) begin
            miscompares++; $display("FAIL rst_mem_rel: state=%0d sel=%b exp 0/0", state, mem_addr_sel); end
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
            miscompares++; $display("FAIL rst_mem_fetch: req=%b sel=%b exp 1/0", mem_req, mem_addr_sel); end
    endtask

    task automatic test_illegal();
        issue(32'h0000007F, 3'd2);
`ifdef ILLEGAL_OPCODE_TRAP_EN
        tick();
        vectors++; if (state !== 3'd5 || illegal !== 1'b1 || pc_we !== 1'b0) begin
            miscompares++; $display("FAIL illegal_trap: state=%0d ill=%b pcwe=%b exp 5/1/0", state, illegal, pc_we); end
`else
        vectors++; if (pc_we !== 1'b1 || pc_src !== 2'd0 || reg_we !== 1'b0) begin
            miscompares++; $display("FAIL illegal_nop: pcwe=%b pcs=%0d rwe=%b exp 1/0/0", pc_we, pc_src, reg_we); end
        tick();
        vectors++; if (state !== 3'd0 || illegal !== 1'b0) begin
            miscompares++; $display("FAIL illegal_done: state=%0d ill=%b exp 0/0", state, illegal); end
`endif
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b1; mem_ack = 1'b0; mem_rdata = '0; br_taken = 1'b0;
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_branch();
        test_wb_types();
        test_nop();
        test_timeout_ack();
        test_timeout();
        test_reset_mid_mem();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
